// File: rtl/sti_dac_gen2_if.sv
// Bundle of the frame-load, serial-out and pixel-memory-write signals of sti_dac_gen2.
// master: drives load/pi_* and observes pi_ready, serial and pixel outputs.
// slave:  the converter itself; samples load/pi_* and drives everything else.
interface sti_dac_gen2_if #(
    parameter int PI_W      = 16,
    parameter int PW        = 8,
    parameter int MEM_DEPTH = 256
);
    localparam int AW = $clog2(MEM_DEPTH);

    logic            load;
    logic [PI_W-1:0] pi_data;
    logic [1:0]      pi_length;
    logic            pi_fill;
    logic            pi_msb;
    logic            pi_low;
    logic            pi_end;
    logic            pi_ready;
    logic            so_data;
    logic            so_valid;
    logic            pixel_wr;
    logic [AW-1:0]   pixel_addr;
    logic [PW-1:0]   pixel_dataout;
    logic            pixel_finish;

    modport master (
        output load, pi_data, pi_length, pi_fill, pi_msb, pi_low, pi_end,
        input  pi_ready, so_data, so_valid, pixel_wr, pixel_addr, pixel_dataout, pixel_finish
    );

    modport slave (
        input  load, pi_data, pi_length, pi_fill, pi_msb, pi_low, pi_end,
        output pi_ready, so_data, so_valid, pixel_wr, pixel_addr, pixel_dataout, pixel_finish
    );
endinterface

// File: rtl/sti_dac_gen2.sv
// Serialises a 1..4 half-word frame on so_data/so_valid and packs the same bits into PW-bit pixel words.
// Latency: first bit valid the cycle after the load edge; a word is written the cycle after its last bit.
// Backpressure: pi_ready gates load/pi_end; low while a frame shifts, during flush and forever once DONE.
// Ports: clk, reset (async, active-high), bus (sti_dac_gen2_if.slave: load/pi_* in, so_*/pixel_* out).
// Optional: define STI_PARITY_EN to append one even-parity bit after each frame (not packed to memory).
module sti_dac_gen2 #(
    parameter int PI_W      = 16,
    parameter int PW        = 8,
    parameter int MEM_DEPTH = 256
) (
    input logic           clk,
    input logic           reset,
    sti_dac_gen2_if.slave bus
);
    localparam int UNIT = PI_W / 2;
    localparam int BW   = 2 * PI_W;
    localparam int AW   = $clog2(MEM_DEPTH);
    localparam int CW   = $clog2(BW + 1);
    localparam int FW   = $clog2(PW + 1);

    typedef enum logic [2:0] {S_IDLE, S_SHIFT, S_PARITY, S_FLUSH, S_DONE} state_t;

    state_t          state_q;
    logic [BW-1:0]   buf_q;
    logic [CW-1:0]   cnt_q;        // bits still to emit after the current one
    logic            msb_q;
    logic            par_q;
    logic            so_data_q;
    logic            so_valid_q;
    logic            so_par_q;     // current serial bit is the parity bit
    logic [PW-1:0]   acc_q;
    logic [FW-1:0]   fill_q;
    logic [AW-1:0]   addr_q;
    logic            full_q;       // address MEM_DEPTH-1 already written
    logic            pixel_wr_q;
    logic [AW-1:0]   pixel_addr_q;
    logic [PW-1:0]   pixel_dat_q;
    logic            finish_q;
    logic            ready_q;

    logic [UNIT-1:0] half_w;
    logic [BW-1:0]   lo_w;         // frame with bit 0 at buffer bit 0
    logic [BW-1:0]   al_w;         // frame with bit N-1 at buffer bit BW-1
    logic [CW-1:0]   n_w;
    logic            first_w;
    logic            next_w;
    logic            pack_vld_w;
    logic            word_done_w;
    logic            last_addr_w;
    logic [PW-1:0]   pack_word_w;
    logic [PW-1:0]   part_word_w;
    logic            full_d;

    always_comb begin
        half_w = bus.pi_low ? bus.pi_data[PI_W-1:UNIT] : bus.pi_data[UNIT-1:0];
        n_w    = CW'(BW);
        lo_w   = {{PI_W{1'b0}}, bus.pi_data};
        al_w   = lo_w;
        case (bus.pi_length)
            2'b00: begin
                n_w  = CW'(UNIT);
                lo_w = {{(BW-UNIT){1'b0}}, half_w};
                al_w = {half_w, {(BW-UNIT){1'b0}}};
            end
            2'b01: begin
                n_w  = CW'(PI_W);
                al_w = {bus.pi_data, {PI_W{1'b0}}};
            end
            2'b10: begin
                n_w = CW'(3 * UNIT);
                if (bus.pi_fill) begin
                    lo_w = {{UNIT{1'b0}}, bus.pi_data, {UNIT{1'b0}}};
                    al_w = {bus.pi_data, {PI_W{1'b0}}};
                end else begin
                    al_w = {{UNIT{1'b0}}, bus.pi_data, {UNIT{1'b0}}};
                end
            end
            default: begin
                if (bus.pi_fill) begin
                    lo_w = {bus.pi_data, {PI_W{1'b0}}};
                    al_w = lo_w;
                end
            end
        endcase
        first_w = bus.pi_msb ? al_w[BW-1] : lo_w[0];
        next_w  = msb_q ? buf_q[BW-1] : buf_q[0];
    end

    // The packer consumes the registered serial bit, so a completed word is
    // written one cycle after its last bit appears on so_data.
    assign pack_vld_w  = so_valid_q & ~so_par_q;
    assign pack_word_w = (acc_q << 1) | PW'(so_data_q);
    assign word_done_w = pack_vld_w && (fill_q == FW'(PW - 1));
    assign last_addr_w = (addr_q == AW'(MEM_DEPTH - 1));
    assign full_d      = full_q | (word_done_w & last_addr_w);
    assign part_word_w = acc_q << (FW'(PW) - fill_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            buf_q        <= '0;
            cnt_q        <= '0;
            msb_q        <= 1'b0;
            par_q        <= 1'b0;
            so_data_q    <= 1'b0;
            so_valid_q   <= 1'b0;
            so_par_q     <= 1'b0;
            acc_q        <= '0;
            fill_q       <= '0;
            addr_q       <= '0;
            full_q       <= 1'b0;
            pixel_wr_q   <= 1'b0;
            pixel_addr_q <= '0;
            pixel_dat_q  <= '0;
            finish_q     <= 1'b0;
            ready_q      <= 1'b1;
        end else begin
            pixel_wr_q <= 1'b0;

            // Bit packer; words reaching a full memory are dropped.
            if (pack_vld_w) begin
                acc_q <= pack_word_w;
                if (word_done_w) begin
                    fill_q <= '0;
                    if (!full_q) begin
                        pixel_wr_q   <= 1'b1;
                        pixel_addr_q <= addr_q;
                        pixel_dat_q  <= pack_word_w;
                        addr_q       <= addr_q + 1'b1;
                        full_q       <= full_d;
                    end
                end else begin
                    fill_q <= fill_q + 1'b1;
                end
            end

            case (state_q)
                S_IDLE: begin
                    if (bus.pi_end) begin
                        ready_q <= 1'b0;
                        if (full_q) begin
                            state_q  <= S_DONE;
                            finish_q <= 1'b1;
                        end else begin
                            state_q <= S_FLUSH;
                        end
                    end else if (bus.load) begin
                        // First bit goes out at the load edge itself.
                        ready_q    <= 1'b0;
                        state_q    <= S_SHIFT;
                        msb_q      <= bus.pi_msb;
                        buf_q      <= bus.pi_msb ? (al_w << 1) : (lo_w >> 1);
                        cnt_q      <= n_w - CW'(1);
                        so_valid_q <= 1'b1;
                        so_data_q  <= first_w;
                        par_q      <= first_w;
                    end
                end
                S_SHIFT: begin
                    if (cnt_q != '0) begin
                        so_data_q <= next_w;
                        par_q     <= par_q ^ next_w;
                        buf_q     <= msb_q ? (buf_q << 1) : (buf_q >> 1);
                        cnt_q     <= cnt_q - 1'b1;
                    end else begin
`ifdef STI_PARITY_EN
                        so_data_q <= par_q;
                        so_par_q  <= 1'b1;
                        state_q   <= S_PARITY;
`else
                        so_valid_q <= 1'b0;
                        so_data_q  <= 1'b0;
                        if (full_d) begin
                            state_q  <= S_DONE;
                            finish_q <= 1'b1;
                        end else begin
                            state_q <= S_IDLE;
                            ready_q <= 1'b1;
                        end
`endif
                    end
                end
                S_PARITY: begin
                    so_valid_q <= 1'b0;
                    so_data_q  <= 1'b0;
                    so_par_q   <= 1'b0;
                    if (full_d) begin
                        state_q  <= S_DONE;
                        finish_q <= 1'b1;
                    end else begin
                        state_q <= S_IDLE;
                        ready_q <= 1'b1;
                    end
                end
                S_FLUSH: begin
                    // Partial word first (left-aligned), then zeros to the top address.
                    if (full_q) begin
                        state_q  <= S_DONE;
                        finish_q <= 1'b1;
                    end else begin
                        pixel_wr_q   <= 1'b1;
                        pixel_addr_q <= addr_q;
                        pixel_dat_q  <= (fill_q != '0) ? part_word_w : '0;
                        fill_q       <= '0;
                        acc_q        <= '0;
                        addr_q       <= addr_q + 1'b1;
                        full_q       <= last_addr_w;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.pi_ready      = ready_q;
    assign bus.so_data       = so_data_q;
    assign bus.so_valid      = so_valid_q;
    assign bus.pixel_wr      = pixel_wr_q;
    assign bus.pixel_addr    = pixel_addr_q;
    assign bus.pixel_dataout = pixel_dat_q;
    assign bus.pixel_finish  = finish_q;
endmodule

// File: tb/tb_sti_dac_gen2.sv
// Directed bench for sti_dac_gen2: default instance (PI_W=16) plus a PI_W=4 instance for odd-length flush.
// Outputs are sampled 1 time unit after each rising edge; stimulus changes on falling edges.
// Expected serial streams and pixel writes are hand-computed constants.
module tb_sti_dac_gen2;
    logic clk;
    logic rst;
    logic rst2;
    int   n_chk = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   last_wr2 = 0;
    int   fin2 = -1;
    int   nv;
    logic [63:0] bits;
    logic [15:0] wq[$];
    logic [15:0] wq2[$];
    logic        sq[$];

    sti_dac_gen2_if #(.PI_W(16), .PW(8), .MEM_DEPTH(256)) bus ();
    sti_dac_gen2_if #(.PI_W(4), .PW(8), .MEM_DEPTH(256)) bus2 ();

    sti_dac_gen2 #(.PI_W(16), .PW(8), .MEM_DEPTH(256)) u_dut (.clk(clk), .reset(rst), .bus(bus.slave));
    sti_dac_gen2 #(.PI_W(4), .PW(8), .MEM_DEPTH(256)) u_dut4 (.clk(clk), .reset(rst2), .bus(bus2.slave));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", n_chk, n_err);
        $fatal(1, "watchdog");
    end

    always @(posedge clk) begin
        cyc++;
        #1;
        if (!rst) begin
            if (bus.so_valid) sq.push_back(bus.so_data);
            if (bus.pixel_wr) wq.push_back({bus.pixel_addr, bus.pixel_dataout});
        end
        if (!rst2) begin
            if (bus2.pixel_wr) begin
                wq2.push_back({bus2.pixel_addr, bus2.pixel_dataout});
                last_wr2 = cyc;
            end
            if (bus2.pixel_finish && fin2 < 0) fin2 = cyc;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] wat(input int i);
        if (i < wq.size()) return wq[i];
        return 16'hxxxx;
    endfunction

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Loads one frame on the default instance at the first pi_ready cycle and
    // waits for the frame to end; returns the captured serial stream.
    task automatic send(input logic [15:0] d, input logic [1:0] len, input logic fill, input logic msb,
                        input logic low, input bit hs, output int n, output logic [63:0] b);
        int t;
        t = 0;
        @(negedge clk);
        while (!bus.pi_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) chk("wait_ready", bus.pi_ready, 1);
        sq.delete();
        wq.delete();
        bus.pi_data = d; bus.pi_length = len; bus.pi_fill = fill; bus.pi_msb = msb; bus.pi_low = low;
        bus.load = 1'b1;
        @(negedge clk);
        bus.load = 1'b0;
        if (hs) begin
            chk("first_valid", bus.so_valid, 1);
            chk("ready_drop", bus.pi_ready, 0);
        end
        t = 0;
        while (!(bus.pi_ready || bus.pixel_finish) && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) chk("frame_end", bus.pi_ready, 1);
        if (hs) chk("valid_at_ready", bus.so_valid, 0);
        n = sq.size();
        b = '0;
        foreach (sq[i]) b = {b[62:0], sq[i]};
    endtask

    task automatic send2(input logic [3:0] d, input logic [1:0] len, input logic fill, input logic msb);
        int t;
        t = 0;
        @(negedge clk);
        while (!bus2.pi_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        bus2.pi_data = d; bus2.pi_length = len; bus2.pi_fill = fill; bus2.pi_msb = msb; bus2.pi_low = 1'b0;
        bus2.load = 1'b1;
        @(negedge clk);
        bus2.load = 1'b0;
        t = 0;
        while (!bus2.pi_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) chk("frame2_end", bus2.pi_ready, 1);
    endtask

    initial begin
        int bad;
        int t;
        rst = 1'b1; rst2 = 1'b1;
        bus.load = 1'b0; bus.pi_data = '0; bus.pi_length = '0; bus.pi_fill = 1'b0;
        bus.pi_msb = 1'b0; bus.pi_low = 1'b0; bus.pi_end = 1'b0;
        bus2.load = 1'b0; bus2.pi_data = '0; bus2.pi_length = '0; bus2.pi_fill = 1'b0;
        bus2.pi_msb = 1'b0; bus2.pi_low = 1'b0; bus2.pi_end = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", bus.pi_ready, 1);
        chk("rst_so_valid", bus.so_valid, 0);
        chk("rst_so_data", bus.so_data, 0);
        chk("rst_pixel_wr", bus.pixel_wr, 0);
        chk("rst_pixel_addr", bus.pixel_addr, 0);
        chk("rst_dataout", bus.pixel_dataout, 0);
        chk("rst_finish", bus.pixel_finish, 0);
        rst = 1'b0;

        // 16-bit frame, MSB first
        send(16'hA5C3, 2'b01, 1'b0, 1'b1, 1'b0, 1'b1, nv, bits);
        chk("t1_nvalid", nv, 16);
        chk("t1_bits", bits, 64'hA5C3);
        chk("t1_nwr", wq.size(), 2);
        chk("t1_w0", wat(0), 16'h00A5);
        chk("t1_w1", wat(1), 16'h01C3);

        // upper half, LSB first; pi_fill must not matter for this length
        pulse_reset();
        send(16'h8100, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1, nv, bits);
        chk("t2_nvalid", nv, 8);
        chk("t2_bits", bits, 64'h81);
        chk("t2_w0", wat(0), 16'h0081);

        // 24-bit MSB-aligned, then back-to-back 32-bit LSB-aligned
        pulse_reset();
        send(16'hFFFF, 2'b10, 1'b1, 1'b1, 1'b0, 1'b1, nv, bits);
        chk("t3_nvalid", nv, 24);
        chk("t3_bits", bits, 64'hFFFF00);
        chk("t3_nwr", wq.size(), 3);
        chk("t3_w0", wat(0), 16'h00FF);
        chk("t3_w1", wat(1), 16'h01FF);
        chk("t3_w2", wat(2), 16'h0200);
        send(16'h1234, 2'b11, 1'b0, 1'b1, 1'b0, 1'b1, nv, bits);
        chk("t3b_nvalid", nv, 32);
        chk("t3b_bits", bits, 64'h0000_1234);
        chk("t3b_w3", wat(0), 16'h0300);
        chk("t3b_w5", wat(2), 16'h0512);
        chk("t3b_w6", wat(3), 16'h0634);

        // reset while bit 5 is on the wire
        pulse_reset();
        @(negedge clk);
        bus.pi_data = 16'hA5C3; bus.pi_length = 2'b01; bus.pi_msb = 1'b1; bus.load = 1'b1;
        @(negedge clk);
        bus.load = 1'b0;
        repeat (4) @(negedge clk);
        chk("t5_mid_valid", bus.so_valid, 1);
        rst = 1'b1;
        #1;
        chk("t5_so_valid", bus.so_valid, 0);
        chk("t5_so_data", bus.so_data, 0);
        chk("t5_ready", bus.pi_ready, 1);
        chk("t5_pixel_wr", bus.pixel_wr, 0);
        @(negedge clk);
        rst = 1'b0;
        send(16'h3C0F, 2'b01, 1'b0, 1'b1, 1'b0, 1'b1, nv, bits);
        chk("t5_w0", wat(0), 16'h003C);
        chk("t5_w1", wat(1), 16'h010F);

        // LSB-first single one: parity bit (when built in) is 1
        pulse_reset();
        send(16'h0001, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, nv, bits);
`ifdef STI_PARITY_EN
        chk("t6_nvalid", nv, 17);
        chk("t6_bits", bits, 64'h10001);
`else
        chk("t6_nvalid", nv, 16);
        chk("t6_bits", bits, 64'h8000);
`endif
        chk("t6_nwr", wq.size(), 2);
        chk("t6_w0", wat(0), 16'h0080);
        chk("t6_w1", wat(1), 16'h0100);

        // overflow: 253 words, then a 4-word frame of which one word is dropped
        pulse_reset();
        send(16'h00AA, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, nv, bits);
        chk("ov_w0", wat(0), 16'h00AA);
        for (int i = 0; i < 63; i++) send(16'(i * 3 + 1), 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, nv, bits);
        chk("ov_pre_ready", bus.pi_ready, 1);
        send(16'hBEEF, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0, nv, bits);
`ifdef STI_PARITY_EN
        chk("ov_nvalid", nv, 33);
`else
        chk("ov_nvalid", nv, 32);
`endif
        chk("ov_nwr", wq.size(), 3);
        chk("ov_w253", wat(0), 16'hFDBE);
        chk("ov_w254", wat(1), 16'hFEEF);
        chk("ov_w255", wat(2), 16'hFF00);
        chk("ov_finish", bus.pixel_finish, 1);
        chk("ov_ready", bus.pi_ready, 0);
        bus.pi_length = 2'b01; bus.load = 1'b1;
        @(negedge clk);
        bus.load = 1'b0;
        @(negedge clk);
        chk("ov_load_ignored", bus.so_valid, 0);

        // PI_W=4 instance: 2 words + 4 spare bits 1011, then end of stream
        @(negedge clk);
        rst2 = 1'b0;
        send2(4'hA, 2'b11, 1'b1, 1'b1);
        send2(4'h5, 2'b11, 1'b0, 1'b1);
        send2(4'hB, 2'b01, 1'b0, 1'b1);
        bus2.pi_end = 1'b1;
        @(negedge clk);
        bus2.pi_end = 1'b0;
        t = 0;
        while (!bus2.pixel_finish && t < 400) begin
            @(negedge clk);
            t++;
        end
        chk("t4_finish", bus2.pixel_finish, 1);
        chk("t4_nwr", wq2.size(), 256);
        chk("t4_w0", (wq2.size() > 0) ? wq2[0] : 16'hxxxx, 16'h00A0);
        chk("t4_w1", (wq2.size() > 1) ? wq2[1] : 16'hxxxx, 16'h0105);
        chk("t4_w2", (wq2.size() > 2) ? wq2[2] : 16'hxxxx, 16'h02B0);
        bad = 0;
        for (int i = 3; i < wq2.size(); i++) if (wq2[i] !== {i[7:0], 8'h00}) bad++;
        chk("t4_zero_fill", bad, 0);
        chk("t4_finish_lat", fin2 - last_wr2, 1);
        bus2.load = 1'b1;
        bus2.pi_end = 1'b1;
        @(negedge clk);
        bus2.load = 1'b0;
        bus2.pi_end = 1'b0;
        @(negedge clk);
        chk("t4_load_ignored", bus2.so_valid, 0);
        chk("t4_ready_low", bus2.pi_ready, 0);
        chk("t4_finish_sticky", bus2.pixel_finish, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
